// File: rtl/cpu_ctrl.sv
// Fetch/decode/control FSM for the 16-bit CPU: owns PC, IR and DA and drives the datapath.
// Define CPU_CTRL_BRANCH_EN to build B/Bcc/BL/BX/BLX; otherwise opcodes 001/010 halt.
module cpu_ctrl #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     read_data,
  input  logic [15:0]     datapath_out,
  input  logic [2:0]      Z_out,
  output logic [1:0]      mem_cmd,
  output logic [PC_W-1:0] mem_addr,
  output logic [2:0]      readnum,
  output logic [2:0]      writenum,
  output logic [1:0]      shift,
  output logic [1:0]      ALUop,
  output logic [1:0]      vsel,
  output logic            write,
  output logic            asel,
  output logic            bsel,
  output logic            loada,
  output logic            loadb,
  output logic            loadc,
  output logic            loads,
  output logic            shift_ctrl,
  output logic [15:0]     sximm8,
  output logic [15:0]     sximm5,
  output logic [PC_W-1:0] PC,
  output logic            halted
);

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPD, S_DEC, S_WIMM, S_GETA, S_GETB, S_EXE, S_WB,
    S_ADDR, S_LDDA, S_RD1, S_RD2, S_GETBD, S_PASS, S_WR,
`ifdef CPU_CTRL_BRANCH_EN
    S_BR, S_BL, S_LINK, S_LDPC,
`endif
    S_HALT
  } state_t;

  state_t state, next_state, dec_target;
  logic [15:0] ir;
  logic [PC_W-1:0] da;
  logic addr_sel;
  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  logic unused_inputs;

  assign opcode   = ir[15:13];
  assign op       = ir[12:11];
  assign rn       = ir[10:8];
  assign rd       = ir[7:5];
  assign sh       = ir[4:3];
  assign rm       = ir[2:0];
  assign sximm8   = {{8{ir[7]}}, ir[7:0]};
  assign sximm5   = {{11{ir[4]}}, ir[4:0]};
  assign mem_addr = addr_sel ? PC : da;
  assign unused_inputs = ^{datapath_out, Z_out};

`ifdef CPU_CTRL_BRANCH_EN
  logic taken;
  logic [PC_W-1:0] br_target;

  // Condition field shares the Rn bits; flags are {V,N,Z}.
  always_comb begin
    taken = 1'b0;
    case (rn)
      3'b000: taken = 1'b1;
      3'b001: taken = Z_out[0];
      3'b010: taken = ~Z_out[0];
      3'b011: taken = Z_out[1] ^ Z_out[2];
      3'b100: taken = (Z_out[1] ^ Z_out[2]) | Z_out[0];
      default: taken = 1'b0;
    endcase
  end

  assign br_target = PC + sximm8[PC_W-1:0];
`endif

  always_comb begin
    dec_target = S_HALT;
    case ({opcode, op})
      5'b110_10: dec_target = S_WIMM;
      5'b110_00: dec_target = S_GETB;
      5'b101_00, 5'b101_01, 5'b101_10: dec_target = S_GETA;
      5'b101_11: dec_target = S_GETB;
      5'b011_00, 5'b100_00: dec_target = S_GETA;
`ifdef CPU_CTRL_BRANCH_EN
      5'b001_00: dec_target = S_BR;
      5'b010_11: dec_target = S_BL;
      5'b010_00, 5'b010_10: dec_target = S_GETBD;
`endif
      default: dec_target = S_HALT;
    endcase
  end

  always_comb begin
    next_state = state;
    mem_cmd    = MEM_NONE;
    addr_sel   = 1'b0;
    readnum    = 3'd0;
    writenum   = 3'd0;
    shift      = 2'b00;
    ALUop      = 2'b00;
    vsel       = 2'b00;
    write      = 1'b0;
    asel       = 1'b0;
    bsel       = 1'b0;
    loada      = 1'b0;
    loadb      = 1'b0;
    loadc      = 1'b0;
    loads      = 1'b0;
    shift_ctrl = 1'b0;
    halted     = 1'b0;
    case (state)
      S_RST:  next_state = S_IF1;
      S_IF1:  begin addr_sel = 1'b1; mem_cmd = MEM_READ; next_state = S_IF2; end
      S_IF2:  begin addr_sel = 1'b1; mem_cmd = MEM_READ; next_state = S_UPD; end
      S_UPD:  next_state = S_DEC;
      S_DEC:  next_state = dec_target;
      S_WIMM: begin vsel = 2'b10; writenum = rn; write = 1'b1; next_state = S_IF1; end
      S_GETA: begin
        readnum = rn; loada = 1'b1;
        next_state = (opcode == 3'b101) ? S_GETB : S_ADDR;
      end
      S_GETB: begin readnum = rm; loadb = 1'b1; next_state = S_EXE; end
      // MOV and MVN ignore A; CMP only updates the flags.
      S_EXE: begin
        asel  = (opcode == 3'b110) || (op == 2'b11);
        shift = sh;
        ALUop = (opcode == 3'b101) ? op : 2'b00;
        if ((opcode == 3'b101) && (op == 2'b01)) begin
          loads = 1'b1; next_state = S_IF1;
        end else begin
          loadc = 1'b1; next_state = S_WB;
        end
      end
      S_WB:   begin writenum = rd; write = 1'b1; next_state = S_IF1; end
      S_ADDR: begin bsel = 1'b1; shift_ctrl = 1'b1; loadc = 1'b1; next_state = S_LDDA; end
      S_LDDA: next_state = (opcode == 3'b100) ? S_GETBD : S_RD1;
      S_RD1:  begin mem_cmd = MEM_READ; next_state = S_RD2; end
      S_RD2:  begin
        mem_cmd = MEM_READ; vsel = 2'b11; writenum = rd; write = 1'b1; next_state = S_IF1;
      end
      S_GETBD: begin readnum = rd; loadb = 1'b1; next_state = S_PASS; end
      S_PASS: begin
        asel = 1'b1; shift_ctrl = 1'b1; loadc = 1'b1;
`ifdef CPU_CTRL_BRANCH_EN
        if (opcode == 3'b100)   next_state = S_WR;
        else if (op == 2'b10)   next_state = S_LINK;
        else                    next_state = S_LDPC;
`else
        next_state = S_WR;
`endif
      end
      S_WR:   begin mem_cmd = MEM_WRITE; next_state = S_IF1; end
`ifdef CPU_CTRL_BRANCH_EN
      S_BR:   next_state = S_IF1;
      S_BL:   begin writenum = 3'd7; vsel = 2'b01; write = 1'b1; next_state = S_IF1; end
      S_LINK: begin writenum = 3'd7; vsel = 2'b01; write = 1'b1; next_state = S_LDPC; end
      S_LDPC: next_state = S_IF1;
`endif
      S_HALT: halted = 1'b1;
      default: next_state = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RST;
    else       state <= next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC <= RESET_PC;
      ir <= '0;
      da <= '0;
    end else begin
      case (state)
        S_IF2:  ir <= read_data;
        S_UPD:  PC <= PC + PC_W'(1);
        S_LDDA: da <= datapath_out[PC_W-1:0];
`ifdef CPU_CTRL_BRANCH_EN
        S_BR:   if (taken) PC <= br_target;
        S_BL:   PC <= br_target;
        S_LDPC: PC <= datapath_out[PC_W-1:0];
`endif
        default: ;
      endcase
    end
  end

endmodule
